// File: rtl/combo_lock_fsm_pkg.sv
// Shared types and constants for the combination lock and the LED blinker
// that consumes its complete word.
package combo_lock_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } lock_state_e;

  localparam logic [7:0] COMPLETE_ON  = 8'hFF;
  localparam logic [7:0] COMPLETE_OFF = 8'h00;

  localparam int DWELL_W = 23;

  // One accepted key-down: sym is only meaningful when bad is clear.
  typedef struct packed {
    logic       vld;
    logic       bad;
    logic [1:0] sym;
  } press_t;

  // Expected button index for press number idx (0 = first, taken from [7:6]).
  function automatic logic [1:0] code_field(input logic [7:0] code, input logic [1:0] idx);
    case (idx)
      2'd0:    return code[7:6];
      2'd1:    return code[5:4];
      2'd2:    return code[3:2];
      default: return code[1:0];
    endcase
  endfunction

endpackage

// File: rtl/combo_lock_fsm_key_debounce.sv
// Four-button synchronizer, debouncer and press-event/symbol generator.
module key_debounce
  import combo_lock_fsm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 10000
) (
  input  logic       lock_clk,
  input  logic       lock_rst,
  input  logic [3:0] key,
  output press_t     press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    sync1, sync2, sync_prev;
  logic [3:0]    deb, deb_prev;
  logic [CW-1:0] cnt;
  logic          armed;
  logic          load;
  logic [1:0]    enc_sym;
  logic          one_hot;

  assign load = (cnt == CNT_LAST) && (sync2 == sync_prev);

  always_comb begin
    enc_sym = 2'd0;
    for (int i = 0; i < 4; i++)
      if (deb[i]) enc_sym = 2'(i);
    one_hot = (deb != 4'd0) && ((deb & (deb - 4'd1)) == 4'd0);
  end

  // armed stays low until a released (all-zero) value has been debounced,
  // so keys held through reset cannot fire an event.
  always_ff @(posedge lock_clk) begin
    if (lock_rst) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      cnt       <= '0;
      deb       <= '0;
      deb_prev  <= '0;
      armed     <= 1'b0;
      press     <= '0;
    end else begin
      sync1     <= key;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (sync2 != sync_prev)
        cnt <= '0;
      else if (cnt != CNT_LAST)
        cnt <= cnt + 1'b1;
      if (load) deb <= sync2;
      if (load && (sync2 == 4'd0)) armed <= 1'b1;
      deb_prev  <= deb;
      press.vld <= armed && (deb != 4'd0) && (deb_prev == 4'd0);
      press.bad <= !one_hot;
      press.sym <= enc_sym;
    end
  end

endmodule

// File: rtl/combo_lock_fsm.sv
// Four-press combination lock: compares debounced presses against CODE and
// drives the unlock window / lockout with a single shared dwell counter.
module combo_lock_fsm
  import combo_lock_fsm_pkg::*;
#(
  parameter logic [7:0] CODE            = 8'b00_01_10_11,
  parameter int         DEBOUNCE_CYCLES = 10000,
  parameter int         UNLOCK_CYCLES   = 5000000,
  parameter int         LOCKOUT_CYCLES  = 2000000,
  parameter int         ENTRY_TIMEOUT   = 3000000
) (
  input  logic       lock_clk,
  input  logic       lock_rst,
  input  logic [3:0] key,
  input  logic       relock,
  output logic [7:0] complete,
  output logic [2:0] progress,
  output logic       lockout
);

  localparam logic [DWELL_W-1:0] TO_LAST  = DWELL_W'(ENTRY_TIMEOUT - 1);
  localparam logic [DWELL_W-1:0] UNL_LAST = DWELL_W'(UNLOCK_CYCLES - 1);
  localparam logic [DWELL_W-1:0] LCK_LAST = DWELL_W'(LOCKOUT_CYCLES - 1);

  press_t             press;
  lock_state_e        state, state_nx;
  logic [2:0]         prog_nx;
  logic               mism, mism_nx;
  logic [DWELL_W-1:0] dwell, dwell_nx;
  logic               miss;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_debounce (
    .lock_clk (lock_clk),
    .lock_rst (lock_rst),
    .key      (key),
    .press    (press)
  );

  // progress doubles as the index of the code field the next press must match
  assign miss = press.bad || (press.sym != code_field(CODE, progress[1:0]));

  always_comb begin
    state_nx = state;
    prog_nx  = progress;
    mism_nx  = mism;
    dwell_nx = dwell + 1'b1;
    case (state)
      ST_IDLE: begin
        dwell_nx = '0;
        if (press.vld) begin
          state_nx = ST_ENTRY;
          prog_nx  = 3'd1;
          mism_nx  = miss;
        end
      end
      ST_ENTRY: begin
        if (press.vld) begin
          dwell_nx = '0;
          if (progress == 3'd3) begin
            state_nx = (mism || miss) ? ST_LOCKOUT : ST_UNLOCKED;
            prog_nx  = 3'd0;
            mism_nx  = 1'b0;
          end else begin
            prog_nx  = progress + 3'd1;
            mism_nx  = mism || miss;
          end
        end else if (dwell == TO_LAST) begin
          state_nx = ST_IDLE;
          prog_nx  = 3'd0;
          mism_nx  = 1'b0;
          dwell_nx = '0;
        end
      end
      ST_UNLOCKED: begin
        if (relock || (dwell == UNL_LAST)) begin
          state_nx = ST_IDLE;
          dwell_nx = '0;
        end
      end
      default: begin
        if (dwell == LCK_LAST) begin
          state_nx = ST_IDLE;
          dwell_nx = '0;
        end
      end
    endcase
  end

  // Status outputs are registered from the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge lock_clk) begin
    if (lock_rst) begin
      state    <= ST_IDLE;
      progress <= 3'd0;
      mism     <= 1'b0;
      dwell    <= '0;
      complete <= COMPLETE_OFF;
      lockout  <= 1'b0;
    end else begin
      state    <= state_nx;
      progress <= prog_nx;
      mism     <= mism_nx;
      dwell    <= dwell_nx;
      complete <= (state_nx == ST_UNLOCKED) ? COMPLETE_ON : COMPLETE_OFF;
      lockout  <= (state_nx == ST_LOCKOUT);
    end
  end

endmodule
